tcm_dump: RTL and testbench
===========================

# tcm_dump

Synthesizable TCM readout engine: the read-side counterpart of the bench's TCM image load. On a start command it reads a contiguous range of 32-bit TCM words through a single-cycle-latency memory read port. It serialises each word into a byte stream with a valid/ready handshake, so a host (UART bridge or testbench monitor) can retrieve memory contents, e.g. result buffers after `sim_finish`. It sits beside the TCM as a second read master, arbitrated outside this block.

## Interface

- `ADDR_W`, 17: TCM word-address width (131072 words).
- `clk` input 1: single clock; all logic rising-edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start_i` input 1: request a dump; sampled only in IDLE.
- `abort_i` input 1: terminate the current dump; ignored in IDLE.
- `base_addr_i` input ADDR_W: first word address; sampled with `start_i`.
- `word_cnt_i` input ADDR_W+1: number of words, 0..2^ADDR_W; sampled with `start_i`.
- `busy_o` output 1: high in every state except IDLE.
- `done_o` output 1: one-cycle pulse at the end of a dump, whether complete, aborted or zero-length.
- `mem_rd_o` output 1: read strobe, high for exactly one cycle per word.
- `mem_addr_o` output ADDR_W: word address, valid while `mem_rd_o`=1.
- `mem_rdata_i` input 32: read data, valid in the cycle after `mem_rd_o`.
- `tx_valid_o` output 1: byte available.
- `tx_data_o` output 8: byte value.
- `tx_last_o` output 1: marks the final byte of the final word; qualified by `tx_valid_o`.
- `tx_ready_i` input 1: sink accepts the byte; a transfer occurs on a rising edge with valid&&ready.

## Operation

- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - `start_i`=1 with `word_cnt_i`!=0: latch base address into the address counter and count into the remaining counter, then go to READ.
  - `start_i`=1 with `word_cnt_i`=0: go to DONE; no memory access.
- READ:
  - Drive `mem_rd_o`=1 with `mem_addr_o` set to the address counter.
  - Go to WAIT.
- WAIT:
  - Capture `mem_rdata_i` into a 32-bit shift register.
  - Clear the byte index to 0 and go to SEND.
- SEND:
  - Drive `tx_valid_o`=1; `tx_data_o` = shift register [7:0].
  - On each transfer, shift right by 8 and increment the byte index.
  - After the transfer of byte index 3:
    - Decrement the remaining counter.
    - Increment the address counter modulo 2^ADDR_W, so the range wraps past the top word to address 0.
    - If remaining reaches 0, go to DONE; otherwise go to READ.
- Byte order is LSB first (byte0 = word[7:0]), so the stream reproduces a little-endian memory image.
- `tx_last_o`=1 only in SEND when remaining = 1 and byte index = 3.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i`=1 in READ, WAIT or SEND:
  - Go to DONE at the next edge; `tx_valid_o` drops and no `tx_last_o` is issued.
  - A byte already transferring on that same edge still counts as delivered.
  - `abort_i` takes priority over all other transitions.
- Stream rule: while `tx_valid_o`=1 and `tx_ready_i`=0, `tx_data_o` and `tx_last_o` hold stable. Abort is the only exception.
- `start_i` outside IDLE is ignored; there is no queuing.
- Reset: state IDLE. All outputs 0, counters 0, shift register 0. Reset asserted mid-dump discards the dump, with no `done_o`.

## Timing

- `start_i` sampled at edge E0:
  - `mem_rd_o`=1 in cycle E0..E1.
  - `mem_rdata_i` is captured at E2.
  - `tx_valid_o`=1 from E2.
- `busy_o` rises in the cycle after the start edge and falls the cycle after DONE.
- With `tx_ready_i` held at 1, one word takes 6 cycles (READ, WAIT, 4×SEND). N words take 6N cycles from READ entry to DONE entry.
- Zero-length dump: DONE one cycle after the start edge, so `done_o` pulses in cycle 2.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

## Test plan

- Single word: mem[0x10]=0x44332211, base=0x10, cnt=1, ready=1.
  - Required: one `mem_rd_o` at address 0x10.
  - Required: bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `tx_last_o` with 0x44, `done_o` 1 cycle later; 6-cycle word period.
- Backpressure: 3 words, `tx_ready_i` toggling pseudo-randomly.
  - Required: the 12 bytes in address/LSB-first order, none duplicated or dropped.
  - Required: data and last stable while stalled; `mem_rd_o` issued only after byte 3 of the previous word.
- Zero count: start with cnt=0.
  - Required: no `mem_rd_o`, no `tx_valid_o`, `done_o` 2 cycles after start; `busy_o` high exactly 1 cycle.
- Wrap: base=0x1FFFF, cnt=2.
  - Required: `mem_addr_o` sequence 0x1FFFF then 0x00000; data from both words in order.
- Abort: 4-word dump with abort asserted during byte 1 of word 2.
  - Required: `tx_valid_o` low the next cycle, no `tx_last_o`, `done_o` pulse, no further `mem_rd_o`.
  - Required: a subsequent start runs a normal dump.
- Start while busy, and reset: a second `start_i` mid-dump with a different base must be ignored. Then assert `rst_n`=0 mid-SEND.
  - Required: all outputs 0 immediately and no `done_o`.

Source files
------------

// File: rtl/tcm_dump.sv
`default_nettype none
// ============================================================================
// Module  : tcm_dump
// Brief   : Reads a contiguous range of 32-bit TCM words and streams them
//           out LSB-first as bytes over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tcm_dump #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_cnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic              busy_q, done_q, rd_q, valid_q, last_q;
    logic              busy_d, done_d, rd_d, valid_d, last_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (word_cnt_i != '0) begin
                        addr_d  = base_addr_i;
                        rem_d   = word_cnt_i;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                shift_d = mem_rdata_i;
                idx_d   = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    shift_d = {8'h00, shift_q[31:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        rem_d   = rem_q - (ADDR_W+1)'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything; a byte accepted on the same edge still
        // advances the shift register above, so it counts as delivered.
        if (abort_i && (state_q == S_READ || state_q == S_WAIT || state_q == S_SEND)) begin
            state_d = S_DONE;
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_d    = (state_d == S_READ);
        valid_d = (state_d == S_SEND);
        last_d  = (state_d == S_SEND) && (rem_d == (ADDR_W+1)'(1)) && (idx_d == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_rd_o   = rd_q;
    assign mem_addr_o = addr_q;
    assign tx_valid_o = valid_q;
    assign tx_data_o  = shift_q[7:0];
    assign tx_last_o  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_tcm_dump.sv
`default_nettype none
// ============================================================================
// Module  : tb_tcm_dump
// Brief   : Table-driven and scoreboard-checked bench for tcm_dump.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tcm_dump;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [16:0] base_addr_i;
    logic [17:0] word_cnt_i;
    logic        busy_o;
    logic        done_o;
    logic        mem_rd_o;
    logic [16:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_last_o;
    logic        tx_ready_i;

    tcm_dump #(.ADDR_W(17)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_last_o   (tx_last_o),
        .tx_ready_i  (tx_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_done   = 0;
    bit bp_mode  = 1'b0;

    logic [8:0]  exp_q[$];
    logic [16:0] addr_q[$];

    typedef struct {
        logic [16:0] base;
        logic [17:0] cnt;
        bit          bp;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [16:0] a);
        logic [31:0] w;
        if (a == 17'h10) return 32'h44332211;
        w = ({15'd0, a} * 32'h9E3779B1) ^ 32'h5BD1E995;
        return w;
    endfunction

    // Single-cycle-latency memory; returns junk when not read.
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= mem_val(mem_addr_o);
        else          mem_rdata_i <= 32'hDEAD_BEEF;
    end

    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit         stalled = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_o) begin
                chk("rd_while_valid", tx_valid_o, 1'b0);
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got read at %0h, required none", mem_addr_o);
                end else begin
                    chk("rd_addr", mem_addr_o, addr_q.pop_front());
                end
            end
            if (tx_last_o) chk("last_qualified", tx_valid_o, 1'b1);
            if (tx_valid_o && stalled) begin
                chk("stall_data", tx_data_o, hold_data);
                chk("stall_last", tx_last_o, hold_last);
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_unexpected: got %0h, required none", tx_data_o);
                end else begin
                    chk("byte", {tx_last_o, tx_data_o}, exp_q.pop_front());
                end
                n_rx++;
            end
            stalled   = tx_valid_o && !tx_ready_i;
            hold_data = tx_data_o;
            hold_last = tx_last_o;
            if (done_o) n_done++;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_words(input logic [16:0] base, input int cnt, input int nbytes_last);
        logic [16:0] a;
        logic [31:0] w;
        for (int i = 0; i < cnt; i++) begin
            a = base + 17'(i);
            w = mem_val(a);
            addr_q.push_back(a);
            for (int b = 0; b < 4; b++) begin
                if (i == cnt - 1 && b >= nbytes_last) break;
                exp_q.push_back({(i == cnt - 1 && b == 3), w[8*b +: 8]});
            end
        end
    endtask

    task automatic do_start(input logic [16:0] base, input logic [17:0] cnt);
        start_i     = 1'b1;
        base_addr_i = base;
        word_cnt_i  = cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_dump(input logic [16:0] base, input logic [17:0] cnt, input bit bp, input int exp_cyc);
        int cyc;
        int bound;
        bp_mode = bp;
        push_words(base, int'(cnt), 4);
        do_start(base, cnt);
        chk("busy_after_start", busy_o, 1'b1);
        cyc   = 0;
        bound = 20 * int'(cnt) + 10;
        while (!done_o && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", done_o, 1'b1);
        if (exp_cyc >= 0) chk("dump_cycles", cyc, exp_cyc);
        @(posedge clk);
        #1;
        chk("done_pulse_end", done_o, 1'b0);
        chk("busy_end", busy_o, 1'b0);
        chk("bytes_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        bp_mode = 1'b0;
    endtask

    initial begin
        int k;
        int done_snap;
        logic [31:0] w;

        vecs[0] = '{17'h00010, 18'd1, 1'b0, 6};
        vecs[1] = '{17'h00080, 18'd3, 1'b1, -1};
        vecs[2] = '{17'h00055, 18'd0, 1'b0, 0};
        vecs[3] = '{17'h1FFFF, 18'd2, 1'b0, 12};
        vecs[4] = '{17'h01234, 18'd5, 1'b0, 30};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        base_addr_i = '0;
        word_cnt_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rd", mem_rd_o, 1'b0);
        chk("rst_valid", tx_valid_o, 1'b0);
        chk("rst_data", tx_data_o, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].base, vecs[v].cnt, vecs[v].bp, vecs[v].exp_cyc);
        end

        // Abort during byte 1 of the second word.
        n_rx = 0;
        push_words(17'h40, 2, 2);
        do_start(17'h40, 18'd4);
        k = 0;
        while (!(n_rx == 5 && tx_valid_o) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        w = mem_val(17'h41);
        chk("abort_byte1", tx_data_o, w[15:8]);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        chk("abort_valid", tx_valid_o, 1'b0);
        chk("abort_last", tx_last_o, 1'b0);
        chk("abort_done", done_o, 1'b1);
        @(posedge clk);
        #1;
        chk("abort_idle", busy_o, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_bytes_left", exp_q.size(), 0);
        chk("abort_reads_left", addr_q.size(), 0);
        run_dump(17'h20, 18'd2, 1'b0, 12);

        // Ignored restart mid-dump, then reset in SEND.
        n_rx = 0;
        push_words(17'h100, 3, 4);
        do_start(17'h100, 18'd3);
        k = 0;
        while (n_rx < 2 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        do_start(17'h200, 18'd1);
        k = 0;
        while (!(n_rx == 6 && tx_valid_o) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("pre_reset_valid", tx_valid_o, 1'b1);
        done_snap = n_done;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_valid", tx_valid_o, 1'b0);
        chk("mid_rst_data", tx_data_o, 8'h00);
        chk("mid_rst_last", tx_last_o, 1'b0);
        chk("mid_rst_rd", mem_rd_o, 1'b0);
        chk("mid_rst_addr", mem_addr_o, 17'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid_rst_done", done_o, 1'b0);
        end
        exp_q.delete();
        addr_q.delete();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_rst", n_done, done_snap);
        run_dump(17'h300, 18'd1, 1'b0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
